// File: rtl/vc_dest_router_pkg.sv
// Shared types and constants for the VC-to-destination router.
package vc_dest_router_pkg;
    localparam int DEF_DATA_WIDTH = 6;
    localparam int DEF_DEST_BIT   = 4;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;
endpackage

// File: rtl/vc_dest_router_if.sv
// VC FIFO read side, D FIFO write side and status bundle of the router.
interface vc_dest_router_if
    import vc_dest_router_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  init;
    logic                  vc0_empty;
    logic                  vc1_empty;
    logic [DATA_WIDTH-1:0] vc0_data;
    logic [DATA_WIDTH-1:0] vc1_data;
    logic                  vc0_pop;
    logic                  vc1_pop;
    logic                  d0_almost_full;
    logic                  d1_almost_full;
    logic                  d0_full;
    logic                  d1_full;
    logic                  d0_push;
    logic                  d1_push;
    logic [DATA_WIDTH-1:0] d_data;
    logic                  active_out;
    logic                  idle_out;
    logic                  error_out;

    modport master (
        output init, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_almost_full, d1_almost_full, d0_full, d1_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, d_data,
               active_out, idle_out, error_out
    );

    modport slave (
        input  init, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_almost_full, d1_almost_full, d0_full, d1_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, d_data,
               active_out, idle_out, error_out
    );
endinterface

// File: rtl/vc_dest_router_vc_arbiter.sv
// Pop select between VC0 and VC1; fixed VC0 priority, or round-robin
// when VC_ROUTER_RR_EN is defined.
module vc_arbiter
    import vc_dest_router_pkg::*;
(
`ifdef VC_ROUTER_RR_EN
    input  logic clk,
    input  logic reset,
`endif
    input  logic i_en,
    input  logic i_stall,
    input  logic i_vc0_empty,
    input  logic i_vc1_empty,
    output logic o_vc0_pop,
    output logic o_vc1_pop,
    output logic o_src
);
    logic w_go;

`ifdef VC_ROUTER_RR_EN
    logic r_last;

    // Holds the VC served most recently; starts as VC1 so VC0 goes first.
    always_ff @(posedge clk) begin
        if (reset)          r_last <= VC1;
        else if (o_vc0_pop) r_last <= VC0;
        else if (o_vc1_pop) r_last <= VC1;
    end
`endif

    always_comb begin
        o_vc0_pop = 1'b0;
        o_vc1_pop = 1'b0;
        w_go      = i_en & ~i_stall;
`ifdef VC_ROUTER_RR_EN
        if (w_go) begin
            if (!i_vc0_empty && !i_vc1_empty) begin
                if (r_last == VC1) o_vc0_pop = 1'b1;
                else               o_vc1_pop = 1'b1;
            end else if (!i_vc0_empty) begin
                o_vc0_pop = 1'b1;
            end else if (!i_vc1_empty) begin
                o_vc1_pop = 1'b1;
            end
        end
`else
        if (w_go) begin
            if (!i_vc0_empty)      o_vc0_pop = 1'b1;
            else if (!i_vc1_empty) o_vc1_pop = 1'b1;
        end
`endif
        o_src = o_vc1_pop ? VC1 : VC0;
    end
endmodule

// File: rtl/vc_dest_router.sv
// Pops VC0/VC1 FIFOs and steers each word to D0/D1 by its destination bit.
// VC_ROUTER_RR_EN selects round-robin instead of fixed VC0 priority.
module vc_dest_router
    import vc_dest_router_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEST_BIT   = DEF_DEST_BIT
)(
    input  logic             clk,
    input  logic             reset,
    vc_dest_router_if.slave  bus
);
    state_t                r_state;
    state_t                w_next;
    logic                  w_run;
    logic                  w_stall;
    logic                  w_vc0_pop;
    logic                  w_vc1_pop;
    logic                  w_src;
    logic [2:1]            r_vld_pipe;
    logic                  r_src;
    logic [DATA_WIDTH-1:0] w_sel;
    logic                  w_dest;
    logic                  w_full;
    logic                  w_fire;
    logic                  r_d0_push;
    logic                  r_d1_push;
    logic [DATA_WIDTH-1:0] r_d_data;
    logic                  r_active;
    logic                  r_idle;
    logic                  r_error;

    assign w_run   = (r_state == IDLE) || (r_state == ACTIVE);
    // Destination is unknown until data returns, so either almost-full stalls.
    assign w_stall = bus.d0_almost_full | bus.d1_almost_full;

    vc_arbiter u_arb (
`ifdef VC_ROUTER_RR_EN
        .clk         (clk),
        .reset       (reset),
`endif
        .i_en        (w_run),
        .i_stall     (w_stall),
        .i_vc0_empty (bus.vc0_empty),
        .i_vc1_empty (bus.vc1_empty),
        .o_vc0_pop   (w_vc0_pop),
        .o_vc1_pop   (w_vc1_pop),
        .o_src       (w_src)
    );

    always_comb begin
        w_next = r_state;
        if (!bus.init) begin
            w_next = INIT;
        end else begin
            case (r_state)
                INIT:    w_next = IDLE;
                IDLE:    if (!bus.vc0_empty || !bus.vc1_empty) w_next = ACTIVE;
                ACTIVE:  if (bus.vc0_empty && bus.vc1_empty && r_vld_pipe == 2'b00)
                             w_next = IDLE;
                default: w_next = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= INIT;
        else       r_state <= w_next;
    end

    // Read data is valid the cycle after the pop; route it from the stage-1 source.
    assign w_sel  = r_src ? bus.vc1_data : bus.vc0_data;
    assign w_dest = w_sel[DEST_BIT];
    assign w_full = w_dest ? bus.d1_full : bus.d0_full;
    assign w_fire = r_vld_pipe[1] & ~w_full;

    // Dropping init flushes in-flight words and clears the sticky error.
    always_ff @(posedge clk) begin
        if (reset || !bus.init) begin
            r_vld_pipe <= 2'b00;
            r_src      <= VC0;
            r_d0_push  <= 1'b0;
            r_d1_push  <= 1'b0;
            r_d_data   <= '0;
            r_active   <= 1'b0;
            r_idle     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[1], w_vc0_pop | w_vc1_pop};
            r_src      <= w_src;
            r_d0_push  <= w_fire & ~w_dest;
            r_d1_push  <= w_fire & w_dest;
            r_d_data   <= w_fire ? w_sel : '0;
            r_active   <= (w_next == ACTIVE);
            r_idle     <= (w_next == IDLE);
            if (r_vld_pipe[1] && w_full) r_error <= 1'b1;
        end
    end

    assign bus.vc0_pop    = w_vc0_pop;
    assign bus.vc1_pop    = w_vc1_pop;
    assign bus.d0_push    = r_d0_push;
    assign bus.d1_push    = r_d1_push;
    assign bus.d_data     = r_d_data;
    assign bus.active_out = r_active;
    assign bus.idle_out   = r_idle;
    assign bus.error_out  = r_error;
endmodule

// File: tb/tb_vc_dest_router.sv
// Self-checking bench: VC FIFO model, push scoreboard, vector table, corner sequences.
module tb_vc_dest_router;
    import vc_dest_router_pkg::*;

    localparam int DW = 6;
    localparam int DB = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          dst;
        logic          drop;
        int            due;
    } exp_t;

    typedef struct packed {
        logic          vc;
        logic [DW-1:0] word;
        logic [1:0]    exp_pop;   // {vc1_pop, vc0_pop}
        logic [1:0]    exp_push;  // {d1_push, d0_push}
        logic [DW-1:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic chk_en;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [DW-1:0] mem0 [64];
    logic [DW-1:0] mem1 [64];
    int   ld0 = 0, ld1 = 0, pp0 = 0, pp1 = 0;
    exp_t expq [$];
    logic popsrc [$];
    exp_t me;
    vec_t tbl [6];

    always #5 clk = ~clk;

    vc_dest_router_if #(.DATA_WIDTH(DW)) vif ();

    vc_dest_router #(.DATA_WIDTH(DW), .DEST_BIT(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif.slave)
    );

    assign vif.vc0_empty = (ld0 == pp0);
    assign vif.vc1_empty = (ld1 == pp1);

    // VC FIFO model with registered read data, plus expected-push bookkeeping.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        while (expq.size() > 0 && expq[0].due <= cyc) void'(expq.pop_front());
        if (expq.size() > 0 && expq[0].due == cyc + 1) begin
            me = expq.pop_front();
            me.drop = me.dst ? vif.d1_full : vif.d0_full;
            expq.push_front(me);
        end
        if (reset === 1'b1) begin
            vif.vc0_data <= '0;
            vif.vc1_data <= '0;
        end
        if (vif.vc0_pop === 1'b1) begin
            me = '{data: mem0[pp0 % 64], dst: mem0[pp0 % 64][DB], drop: 1'b0, due: cyc + 2};
            expq.push_back(me);
            vif.vc0_data <= mem0[pp0 % 64];
            pp0 <= pp0 + 1;
            popsrc.push_back(VC0);
        end else if (vif.vc1_pop === 1'b1) begin
            me = '{data: mem1[pp1 % 64], dst: mem1[pp1 % 64][DB], drop: 1'b0, due: cyc + 2};
            expq.push_back(me);
            vif.vc1_data <= mem1[pp1 % 64];
            pp1 <= pp1 + 1;
            popsrc.push_back(VC1);
        end
        if (reset === 1'b1 || vif.init === 1'b0) expq.delete();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(input logic vc, input logic [DW-1:0] w);
        if (vc == VC0) begin mem0[ld0 % 64] = w; ld0++; end
        else           begin mem1[ld1 % 64] = w; ld1++; end
    endtask

    task automatic sb_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("pop_excl", 32'(vif.vc0_pop & vif.vc1_pop), 32'd0);
                if (expq.size() > 0 && expq[0].due == cyc) begin
                    e = expq[0];
                    if (e.drop)
                        chk("sb_drop", 32'({vif.d1_push, vif.d0_push, vif.d_data}), 32'd0);
                    else
                        chk("sb_push", 32'({vif.d1_push, vif.d0_push, vif.d_data}),
                            32'({e.dst, ~e.dst, e.data}));
                end else begin
                    chk("sb_idle", 32'({vif.d1_push, vif.d0_push, vif.d_data}), 32'd0);
                end
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rst_outs", 32'({vif.d1_push, vif.d0_push, vif.d_data, vif.active_out,
                             vif.idle_out, vif.error_out}), 32'd0);
        @(negedge clk);
        chk("rst_idle", 32'({vif.active_out, vif.idle_out}), 32'b01);
    endtask

    initial begin
        int start, npush, tmo;
        tbl[0] = '{vc: VC0, word: 6'h15, exp_pop: 2'b01, exp_push: 2'b10, exp_data: 6'h15};
        tbl[1] = '{vc: VC0, word: 6'h03, exp_pop: 2'b01, exp_push: 2'b01, exp_data: 6'h03};
        tbl[2] = '{vc: VC1, word: 6'h10, exp_pop: 2'b10, exp_push: 2'b10, exp_data: 6'h10};
        tbl[3] = '{vc: VC1, word: 6'h2F, exp_pop: 2'b10, exp_push: 2'b01, exp_data: 6'h2F};
        tbl[4] = '{vc: VC0, word: 6'h3F, exp_pop: 2'b01, exp_push: 2'b10, exp_data: 6'h3F};
        tbl[5] = '{vc: VC1, word: 6'h00, exp_pop: 2'b10, exp_push: 2'b01, exp_data: 6'h00};

        reset = 1'b1; chk_en = 1'b0;
        vif.init = 1'b0;
        vif.d0_almost_full = 1'b0; vif.d1_almost_full = 1'b0;
        vif.d0_full = 1'b0; vif.d1_full = 1'b0;
        fork sb_loop(); join_none

        // Reset, then hold in INIT, then enable.
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        chk("reset_state", 32'({vif.d1_push, vif.d0_push, vif.d_data, vif.active_out, vif.idle_out,
                                vif.error_out, vif.vc1_pop, vif.vc0_pop}), 32'd0);
        chk_en = 1'b1;
        @(negedge clk);
        chk("init_hold", 32'({vif.active_out, vif.idle_out, vif.vc1_pop, vif.vc0_pop}), 32'd0);
        vif.init = 1'b1;
        @(negedge clk);
        chk("init_to_idle", 32'({vif.active_out, vif.idle_out}), 32'b01);

        // Single-word routing vectors.
        for (int i = 0; i < 6; i++) begin
            load(tbl[i].vc, tbl[i].word);
            #1;
            chk("vec_pop", 32'({vif.vc1_pop, vif.vc0_pop}), 32'(tbl[i].exp_pop));
            repeat (2) @(negedge clk);
            chk("vec_push", 32'({vif.d1_push, vif.d0_push, vif.d_data}),
                32'({tbl[i].exp_push, tbl[i].exp_data}));
            repeat (3) @(negedge clk);
        end

        // Back-to-back routing: 15 -> D1 then 03 -> D0 one cycle later.
        load(VC0, 6'h15); load(VC0, 6'h03);
        repeat (2) @(negedge clk);
        chk("route_d1", 32'({vif.d1_push, vif.d0_push, vif.d_data}), 32'({2'b10, 6'h15}));
        @(negedge clk);
        chk("route_d0", 32'({vif.d1_push, vif.d0_push, vif.d_data}), 32'({2'b01, 6'h03}));
        repeat (3) @(negedge clk);

        // Overflow: D1 full while a D1 word is in flight.
        vif.d1_full = 1'b1;
        load(VC0, 6'h15);
        repeat (2) @(negedge clk);
        chk("ovf_nopush", 32'({vif.d1_push, vif.d0_push}), 32'd0);
        chk("ovf_err", 32'(vif.error_out), 32'd1);
        vif.d1_full = 1'b0;
        load(VC0, 6'h03);
        repeat (4) @(negedge clk);
        chk("ovf_sticky", 32'(vif.error_out), 32'd1);
        pulse_reset();

        // Priority: three words on each VC.
        start = popsrc.size();
        load(VC0, 6'h01); load(VC0, 6'h02); load(VC0, 6'h13);
        load(VC1, 6'h14); load(VC1, 6'h05); load(VC1, 6'h06);
        tmo = 0;
        while (popsrc.size() < start + 6 && tmo < 30) begin @(negedge clk); tmo++; end
        chk("prio_timeout", 32'(tmo < 30), 32'd1);
        if (tmo < 30) begin
            for (int i = 0; i < 6; i++) begin
`ifdef VC_ROUTER_RR_EN
                chk("prio_order", 32'(popsrc[start + i]), 32'(i % 2));
`else
                chk("prio_order", 32'(popsrc[start + i]), 32'(i >= 3));
`endif
            end
        end
        repeat (6) @(negedge clk);

        // Backpressure mid-stream.
        load(VC0, 6'h11); load(VC0, 6'h02); load(VC0, 6'h13);
        load(VC0, 6'h04); load(VC0, 6'h15); load(VC0, 6'h06);
        repeat (2) @(negedge clk);
        vif.d0_almost_full = 1'b1;
        #1;
        chk("bp_stop", 32'(vif.vc0_pop | vif.vc1_pop), 32'd0);
        npush = int'(vif.d0_push | vif.d1_push);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_held", 32'(vif.vc0_pop | vif.vc1_pop), 32'd0);
            npush += int'(vif.d0_push | vif.d1_push);
        end
        chk("bp_inflight", 32'(npush <= 2), 32'd1);
        vif.d0_almost_full = 1'b0;
        #1;
        chk("bp_resume", 32'(vif.vc0_pop), 32'd1);
        tmo = 0;
        while (ld0 != pp0 && tmo < 30) begin @(negedge clk); tmo++; end
        chk("bp_drain", 32'(tmo < 30), 32'd1);
        repeat (5) @(negedge clk);

        // Drop init with two words in flight.
        load(VC1, 6'h17); load(VC1, 6'h08);
        @(negedge clk);
        vif.init = 1'b0;
        @(negedge clk);
        chk("drop_state", 32'({vif.active_out, vif.idle_out}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("drop_nopush", 32'({vif.d1_push, vif.d0_push}), 32'd0);
            @(negedge clk);
        end
        vif.init = 1'b1;
        @(negedge clk);
        chk("reinit_idle", 32'({vif.active_out, vif.idle_out}), 32'b01);
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
